// File: rtl/decode_stage.sv
// RV32I decode stage: register file, instruction classify, immediate extract, ID/EX register, load-use detect (RF_BYPASS_EN: write-through reads).
// Latency 1 clk if_id_* -> id_ex_*; stall freezes ID/EX, id_hazard_stall tells fetch to hold if_id_*.
package instruction_utils;
  typedef enum logic [5:0] {
    INSTR_NOP = 6'd0,
    INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
    INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
    INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
    INSTR_SB, INSTR_SH, INSTR_SW,
    INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
    INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
    INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU,
    INSTR_XOR, INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND
  } rv32i_instr_e;
endpackage

module decode_stage
  import instruction_utils::*;
#(
  parameter bit LOAD_USE_STALL = 1'b1,
  parameter bit RF_RESET_ZERO  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         if_id_valid,
  input  logic [31:0]  if_id_instr,
  input  logic [31:0]  if_id_pc,
  input  logic         wb_write_en,
  input  logic [4:0]   wb_rd_addr,
  input  logic [31:0]  wb_data,
  output rv32i_instr_e id_ex_instr_type,
  output logic [31:0]  id_ex_rs1_data,
  output logic [31:0]  id_ex_rs2_data,
  output logic [4:0]   id_ex_rs1_addr,
  output logic [4:0]   id_ex_rs2_addr,
  output logic [31:0]  id_ex_imm,
  output logic [31:0]  id_ex_pc,
  output logic [4:0]   id_ex_rd_addr,
  output logic         id_ex_write_en,
  output logic         id_ex_illegal,
  output logic         id_hazard_stall
);

  typedef struct packed {
    rv32i_instr_e typ;
    logic [31:0]  rs1_dat;
    logic [31:0]  rs2_dat;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [31:0]  imm;
    logic [31:0]  pc;
    logic [4:0]   rd;
    logic         we;
    logic         ill;
  } id_ex_t;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = if_id_instr[6:0];
  assign f3     = if_id_instr[14:12];
  assign f7     = if_id_instr[31:25];
  assign rd     = if_id_instr[11:7];
  assign rs1    = if_id_instr[19:15];
  assign rs2    = if_id_instr[24:20];
  assign imm_i  = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
  assign imm_s  = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
  assign imm_b  = {{19{if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                   if_id_instr[30:25], if_id_instr[11:8], 1'b0};
  assign imm_u  = {if_id_instr[31:12], 12'b0};
  assign imm_j  = {{11{if_id_instr[31]}}, if_id_instr[31], if_id_instr[19:12],
                   if_id_instr[20], if_id_instr[30:21], 1'b0};

  rv32i_instr_e dec_type;
  logic [31:0]  dec_imm;
  logic         dec_ill, dec_wr_rd, dec_use1, dec_use2;

  always_comb begin
    dec_type  = INSTR_NOP;
    dec_imm   = '0;
    dec_ill   = 1'b0;
    dec_wr_rd = 1'b0;
    dec_use1  = 1'b0;
    dec_use2  = 1'b0;
    case (opcode)
      7'b0110111: begin dec_type = INSTR_LUI;   dec_imm = imm_u; dec_wr_rd = 1'b1; end
      7'b0010111: begin dec_type = INSTR_AUIPC; dec_imm = imm_u; dec_wr_rd = 1'b1; end
      7'b1101111: begin dec_type = INSTR_JAL;   dec_imm = imm_j; dec_wr_rd = 1'b1; end
      7'b1100111: begin
        dec_type = INSTR_JALR; dec_imm = imm_i; dec_wr_rd = 1'b1; dec_use1 = 1'b1;
        dec_ill  = (f3 != 3'b000);
      end
      7'b1100011: begin
        dec_imm = imm_b; dec_use1 = 1'b1; dec_use2 = 1'b1;
        case (f3)
          3'b000:  dec_type = INSTR_BEQ;
          3'b001:  dec_type = INSTR_BNE;
          3'b100:  dec_type = INSTR_BLT;
          3'b101:  dec_type = INSTR_BGE;
          3'b110:  dec_type = INSTR_BLTU;
          3'b111:  dec_type = INSTR_BGEU;
          default: dec_ill  = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec_imm = imm_i; dec_wr_rd = 1'b1; dec_use1 = 1'b1;
        case (f3)
          3'b000:  dec_type = INSTR_LB;
          3'b001:  dec_type = INSTR_LH;
          3'b010:  dec_type = INSTR_LW;
          3'b100:  dec_type = INSTR_LBU;
          3'b101:  dec_type = INSTR_LHU;
          default: dec_ill  = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec_imm = imm_s; dec_use1 = 1'b1; dec_use2 = 1'b1;
        case (f3)
          3'b000:  dec_type = INSTR_SB;
          3'b001:  dec_type = INSTR_SH;
          3'b010:  dec_type = INSTR_SW;
          default: dec_ill  = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec_imm = imm_i; dec_wr_rd = 1'b1; dec_use1 = 1'b1;
        case (f3)
          3'b000: dec_type = INSTR_ADDI;
          3'b010: dec_type = INSTR_SLTI;
          3'b011: dec_type = INSTR_SLTIU;
          3'b100: dec_type = INSTR_XORI;
          3'b110: dec_type = INSTR_ORI;
          3'b111: dec_type = INSTR_ANDI;
          3'b001: begin
            dec_type = INSTR_SLLI; dec_imm = {27'b0, rs2};
            dec_ill  = (f7 != 7'h00);
          end
          default: begin
            // funct3=101: instr[30] picks arithmetic vs logical shift
            dec_type = if_id_instr[30] ? INSTR_SRAI : INSTR_SRLI;
            dec_imm  = {27'b0, rs2};
            dec_ill  = (f7 != 7'h00) && (f7 != 7'h20);
          end
        endcase
      end
      7'b0110011: begin
        dec_wr_rd = 1'b1; dec_use1 = 1'b1; dec_use2 = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: dec_type = INSTR_ADD;
          {7'h20, 3'b000}: dec_type = INSTR_SUB;
          {7'h00, 3'b001}: dec_type = INSTR_SLL;
          {7'h00, 3'b010}: dec_type = INSTR_SLT;
          {7'h00, 3'b011}: dec_type = INSTR_SLTU;
          {7'h00, 3'b100}: dec_type = INSTR_XOR;
          {7'h00, 3'b101}: dec_type = INSTR_SRL;
          {7'h20, 3'b101}: dec_type = INSTR_SRA;
          {7'h00, 3'b110}: dec_type = INSTR_OR;
          {7'h00, 3'b111}: dec_type = INSTR_AND;
          default:         dec_ill  = 1'b1;
        endcase
      end
      7'b0001111: dec_type = INSTR_NOP;
      default:    dec_ill  = 1'b1;
    endcase
    if (dec_ill) begin
      dec_type  = INSTR_NOP;
      dec_imm   = '0;
      dec_wr_rd = 1'b0;
      dec_use1  = 1'b0;
      dec_use2  = 1'b0;
    end
  end

  logic [31:0] rf [32];
  logic        wr_fire;
  logic [31:0] rs1_dat, rs2_dat;

  assign wr_fire = wb_write_en && (wb_rd_addr != 5'd0);

  if (RF_RESET_ZERO) begin : g_rf_rst
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (wr_fire) begin
        rf[wb_rd_addr] <= wb_data;
      end
    end
  end else begin : g_rf_nrst
    always_ff @(posedge clk) begin
      if (wr_fire) rf[wb_rd_addr] <= wb_data;
    end
  end

`ifdef RF_BYPASS_EN
  assign rs1_dat = (rs1 == 5'd0) ? '0 : (wr_fire && wb_rd_addr == rs1) ? wb_data : rf[rs1];
  assign rs2_dat = (rs2 == 5'd0) ? '0 : (wr_fire && wb_rd_addr == rs2) ? wb_data : rf[rs2];
`else
  assign rs1_dat = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_dat = (rs2 == 5'd0) ? '0 : rf[rs2];
`endif

  id_ex_t id_ex_q, dec;
  logic   flush_pend;
  logic   ex_is_load;

  assign dec = '{typ: dec_type, rs1_dat: rs1_dat, rs2_dat: rs2_dat, rs1: rs1, rs2: rs2,
                 imm: dec_imm, pc: if_id_pc, rd: dec_wr_rd ? rd : 5'd0,
                 we: dec_wr_rd && (rd != 5'd0), ill: dec_ill};

  assign ex_is_load = id_ex_q.typ inside {INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU};

  assign id_hazard_stall = LOAD_USE_STALL && if_id_valid && ex_is_load && id_ex_q.we &&
                           ((dec_use1 && rs1 == id_ex_q.rd) || (dec_use2 && rs2 == id_ex_q.rd));

  // A flush arriving under stall is remembered so the squash still lands once stall drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_q    <= '0;
      flush_pend <= 1'b0;
    end else if (stall) begin
      if (flush) flush_pend <= 1'b1;
    end else begin
      flush_pend <= 1'b0;
      if (flush || flush_pend || id_hazard_stall || !if_id_valid) id_ex_q <= '0;
      else                                                        id_ex_q <= dec;
    end
  end

  assign id_ex_instr_type = id_ex_q.typ;
  assign id_ex_rs1_data   = id_ex_q.rs1_dat;
  assign id_ex_rs2_data   = id_ex_q.rs2_dat;
  assign id_ex_rs1_addr   = id_ex_q.rs1;
  assign id_ex_rs2_addr   = id_ex_q.rs2;
  assign id_ex_imm        = id_ex_q.imm;
  assign id_ex_pc         = id_ex_q.pc;
  assign id_ex_rd_addr    = id_ex_q.rd;
  assign id_ex_write_en   = id_ex_q.we;
  assign id_ex_illegal    = id_ex_q.ill;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I instruction decode stage of the mini-rv pipeline, between fetch and execute_stage.
- Holds the 32x32 architectural register file, with its write port driven by writeback.
- Classifies the fetched word into an rv32i_instr_e value from instruction_utils and extracts the sign-extended immediate.
- Registers all decoded fields into the ID/EX register, which feeds execute_stage and the lsu. Also detects load-use hazards and requests a fetch stall.

Parameters:
- LOAD_USE_STALL, 1, 1 enables load-use hazard detection; 0 ties id_hazard_stall low.
- RF_RESET_ZERO, 1, 1 clears all registers on reset; 0 leaves x1..x31 uninitialised (x0 always reads 0).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  1  global pipeline stall; freezes the ID/EX register
- flush  in  1  branch/jump taken (ex_if_take_branch); squashes the instruction being decoded
- if_id_valid  in  1  if_id_instr is valid
- if_id_instr  in  32  fetched instruction word
- if_id_pc  in  32  PC of if_id_instr
- wb_write_en  in  1  register file write enable
- wb_rd_addr  in  5  register file write address
- wb_data  in  32  register file write data
- id_ex_instr_type  out  rv32i_instr_e  decoded instruction
- id_ex_rs1_data  out  32  rs1 read value
- id_ex_rs2_data  out  32  rs2 read value
- id_ex_rs1_addr  out  5  rs1 index, for the forwarding unit
- id_ex_rs2_addr  out  5  rs2 index, for the forwarding unit
- id_ex_imm  out  32  sign-extended immediate
- id_ex_pc  out  32  instruction PC
- id_ex_rd_addr  out  5  destination register
- id_ex_write_en  out  1  destination register write enable
- id_ex_illegal  out  1  unsupported encoding was decoded
- id_hazard_stall  out  1  combinational; fetch must hold if_id_*

Behaviour:
- Reset (rst=0, asynchronous):
  - ID/EX register becomes a bubble: instr_type=INSTR_NOP; all data/address outputs 0; write_en=0; illegal=0.
  - If RF_RESET_ZERO=1, all registers are cleared.
- Latency: decoded fields appear on id_ex_* one clock after if_id_* is presented.
- Decode covers the full RV32I set: LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM, OP.
  - FENCE decodes to INSTR_NOP with illegal=0.
  - ECALL, EBREAK and any other encoding decode to INSTR_NOP with illegal=1 and write_en=0.
- Immediate formats, all sign-extended from instr[31]:
  - I-type and S-type: 12-bit.
  - B-type: 13-bit with bit0=0.
  - J-type: 21-bit with bit0=0.
  - U-type: instr[31:12]<<12.
  - R-type: 0.
  - Shift-immediate: imm=instr[24:20] zero-extended. SRAI vs SRLI selected by instr[30]. A nonzero funct7 other than 0x20 is illegal.
- write_en=1 only for instructions that write rd (ALU ops, loads, JAL, JALR, LUI, AUIPC) and only when rd!=0. write_en=0 for branches, stores and NOP.
- Register file:
  - Read is combinational from instr[19:15] and instr[24:20]; x0 always reads 0.
  - Write happens at the posedge when wb_write_en=1 and wb_rd_addr!=0.
  - Writes proceed even while stall=1.
- Load-use hazard (id_hazard_stall=1):
  - Condition: LOAD_USE_STALL=1, if_id_valid=1, ID/EX holds a load with write_en=1, and the current instruction actually reads rs1 (or rs2) matching id_ex_rd_addr.
  - U-type and J-type instructions use neither rs; I-type and loads use rs1 only.
- ID/EX update priority, evaluated at each posedge:
  - stall=1: hold all outputs. Stall wins over flush and hazard; a pending flush applies at the first non-stalled edge.
  - Otherwise flush=1: load a bubble.
  - Otherwise id_hazard_stall=1: load a bubble. Fetch holds the instruction, so it is re-decoded next cycle; by then the load has left ID/EX and the hazard clears. The bubble lasts exactly 1 cycle.
  - Otherwise if_id_valid=0: load a bubble.
  - Otherwise: load the decoded fields.
- A bubble never asserts write_en or illegal.

Optional Feature:
- Macro: RF_BYPASS_EN.
- When defined: if wb_write_en=1 and wb_rd_addr!=0 equals the rs1 or rs2 read address, the read returns wb_data in the same cycle (write-through).
- When undefined: the read returns the pre-write register value; the forwarding logic downstream covers this case.

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093):
  - During reset: all outputs 0, INSTR_NOP.
  - One edge after the ADDI is presented: INSTR_ADDI, imm=5, rd=1, write_en=1, rs1_data=0.
- WB writes x2=0x1234; next cycle decode ADD x3,x1,x2 (0x002081B3):
  - INSTR_ADD, rs2_data=0x1234, rs1_addr=1, rs2_addr=2.
- BEQ x0,x0,-8 (0xFE000CE3):
  - INSTR_BEQ, imm=0xFFFFFFF8, write_en=0.
  - ADDI x0,x0,1: write_en=0.
  - Word 0x00000073 (ECALL): INSTR_NOP, illegal=1.
- LW x5,0(x1) (0x0000A283) then ADD x6,x5,x5 (0x00528333):
  - id_hazard_stall=1 for exactly one cycle.
  - ID/EX shows LW, then a NOP bubble, then ADD.
  - LUI x7 (rs fields overlapping x5): no hazard.
- ADDI presented with flush=1:
  - Next edge: INSTR_NOP, write_en=0.
  - With stall=1 and flush=1 together: outputs held; the bubble appears on the edge after stall drops.
- WB writes x7=0xDEAD in the same cycle ADD x8,x7,x0 is decoded:
  - rs1_data=0xDEAD with RF_BYPASS_EN, old value 0 without.
- Reset asserted mid-stream: outputs go to the bubble immediately, without waiting for a clock edge.
